// File: rtl/garage_gate_ctrl.sv
// Two-beam garage gate sequencer: synchronizes and debounces the outer (a) and
// inner (b) light beams, tracks entry/exit passages and pulses the occupancy counter.
module garage_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beam_a,
  input  logic       beam_b,
  input  logic       full,
  input  logic       empty,
  output logic       car_in,
  output logic       car_out,
  output logic       gate_open,
  output logic       deny,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IN_A   = 3'd1;
  localparam logic [2:0] S_IN_AB  = 3'd2;
  localparam logic [2:0] S_IN_B   = 3'd3;
  localparam logic [2:0] S_OUT_B  = 3'd4;
  localparam logic [2:0] S_OUT_BA = 3'd5;
  localparam logic [2:0] S_OUT_A  = 3'd6;

  // Debounced beam pair, bit 1 = a (outer), bit 0 = b (inner).
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0] beam_raw;
  logic [1:0] beam_deb_next;

  assign beam_raw = {beam_a, beam_b};

  // The FSM decodes the debouncer's next value so a beam change and the
  // resulting state change land on the same clock edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_beam
      logic       sync1_reg;
      logic       sync2_reg;
      logic       deb_reg;
      logic       deb_next;
      logic [7:0] cnt_reg;
      logic [7:0] cnt_next;

      always_comb begin
        deb_next = deb_reg;
        cnt_next = 8'd0;
        if (sync2_reg != deb_reg) begin
          if (cnt_reg == DEB_LAST) begin
            deb_next = sync2_reg;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          cnt_reg   <= 8'd0;
        end else begin
          sync1_reg <= beam_raw[gi];
          sync2_reg <= sync1_reg;
          deb_reg   <= deb_next;
          cnt_reg   <= cnt_next;
        end
      end

      assign beam_deb_next[gi] = deb_next;
    end
  endgenerate

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic [2:0]  trans_state;
  logic [15:0] timer_reg;
  logic [15:0] timer_next;
  logic        timeout_hit;
  logic        car_in_reg;
  logic        car_in_next;
  logic        car_out_reg;
  logic        car_out_next;
  logic        gate_open_reg;
  logic        deny_reg;
  logic        deny_next;
  logic        fault_reg;

  always_comb begin
    trans_state = state_reg;
    case (state_reg)
      S_IDLE: begin
        // full/empty only matter at the moment a passage starts
        if (beam_deb_next == AB_A && !full) begin
          trans_state = S_IN_A;
        end else if (beam_deb_next == AB_B && !empty) begin
          trans_state = S_OUT_B;
        end
      end
      S_IN_A: begin
        if (beam_deb_next == AB_BOTH)      trans_state = S_IN_AB;
        else if (beam_deb_next == AB_NONE) trans_state = S_IDLE;
      end
      S_IN_AB: begin
        if (beam_deb_next == AB_B)      trans_state = S_IN_B;
        else if (beam_deb_next == AB_A) trans_state = S_IN_A;
      end
      S_IN_B: begin
        if (beam_deb_next == AB_NONE)      trans_state = S_IDLE;
        else if (beam_deb_next == AB_BOTH) trans_state = S_IN_AB;
      end
      S_OUT_B: begin
        if (beam_deb_next == AB_BOTH)      trans_state = S_OUT_BA;
        else if (beam_deb_next == AB_NONE) trans_state = S_IDLE;
      end
      S_OUT_BA: begin
        if (beam_deb_next == AB_A)      trans_state = S_OUT_A;
        else if (beam_deb_next == AB_B) trans_state = S_OUT_B;
      end
      S_OUT_A: begin
        if (beam_deb_next == AB_NONE)      trans_state = S_IDLE;
        else if (beam_deb_next == AB_BOTH) trans_state = S_OUT_BA;
      end
      default: trans_state = S_IDLE;
    endcase
  end

  always_comb begin
    timeout_hit  = (state_reg != S_IDLE) && (trans_state == state_reg) &&
                   (timer_reg == TMO_LAST);
    state_next   = timeout_hit ? S_IDLE : trans_state;
    car_in_next  = (state_reg == S_IN_B)  && (trans_state == S_IDLE);
    car_out_next = (state_reg == S_OUT_A) && (trans_state == S_IDLE);
    deny_next    = (state_reg == S_IDLE) && (beam_deb_next == AB_A) && full;
    if ((state_next != state_reg) || (state_next == S_IDLE)) begin
      timer_next = 16'd0;
    end else begin
      timer_next = timer_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      timer_reg     <= 16'd0;
      car_in_reg    <= 1'b0;
      car_out_reg   <= 1'b0;
      gate_open_reg <= 1'b0;
      deny_reg      <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      car_in_reg    <= car_in_next;
      car_out_reg   <= car_out_next;
      gate_open_reg <= (state_next != S_IDLE);
      deny_reg      <= deny_next;
      fault_reg     <= timeout_hit;
    end
  end

  assign state     = state_reg;
  assign car_in    = car_in_reg;
  assign car_out   = car_out_reg;
  assign gate_open = gate_open_reg;
  assign deny      = deny_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_garage_gate_ctrl.sv
// Bench for garage_gate_ctrl: directed passages plus randomized beam traffic,
// every cycle compared against a sliding-window / route-table reference model.
`timescale 1ns/1ps
module tb_garage_gate_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beam_a = 1'b0;
  logic       beam_b = 1'b0;
  logic       full = 1'b0;
  logic       empty = 1'b0;
  logic       car_in, car_out, gate_open, deny, fault;
  logic [2:0] state;

  garage_gate_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .beam_a(beam_a), .beam_b(beam_b),
    .full(full), .empty(empty), .car_in(car_in), .car_out(car_out),
    .gate_open(gate_open), .deny(deny), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int seen_in = 0, seen_out = 0, seen_fault = 0;
  int last_in_cyc = -1, last_fault_cyc = -1, first_deny = -1;

  // Reference model: raw sample history, debounced pair, route table, dwell count.
  bit [1:0] hist[$];
  bit [1:0] m_deb;
  int       m_state, m_dwell;
  int       tbl[8][4];
  bit       e_in, e_out, e_fault, e_deny;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d, want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic build_table();
    for (int s = 0; s < 8; s++)
      for (int x = 0; x < 4; x++) tbl[s][x] = (s == 7) ? 0 : s;
    // entry route 1->2->3->0, exit route 4->5->6->0; column index is {a,b}
    tbl[1][3] = 2; tbl[1][0] = 0;
    tbl[2][1] = 3; tbl[2][2] = 1;
    tbl[3][0] = 0; tbl[3][3] = 2;
    tbl[4][3] = 5; tbl[4][0] = 0;
    tbl[5][2] = 6; tbl[5][1] = 4;
    tbl[6][0] = 0; tbl[6][3] = 5;
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(2'b00);
    m_deb = 2'b00; m_state = 0; m_dwell = 0;
  endtask

  task automatic model_step();
    bit [1:0] ab;
    int       nxt;
    bit       abort, flip;
    hist.push_front({beam_a, beam_b});
    void'(hist.pop_back());
    // a beam flips once its synchronized view (two clocks old) disagreed for DEB clocks
    for (int b = 0; b < 2; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (hist[j][b] == m_deb[b]) flip = 1'b0;
      if (flip) m_deb[b] = ~m_deb[b];
    end
    ab = m_deb;
    if (m_state == 0) begin
      nxt = 0;
      if (ab == 2'b10 && !full)  nxt = 1;
      if (ab == 2'b01 && !empty) nxt = 4;
    end else begin
      nxt = tbl[m_state][ab];
    end
    abort = 1'b0;
    if (nxt == m_state && m_state != 0) begin
      m_dwell++;
      if (m_dwell == TMO) begin abort = 1'b1; nxt = 0; end
    end else begin
      m_dwell = 0;
    end
    e_in    = (m_state == 3) && (nxt == 0) && !abort;
    e_out   = (m_state == 6) && (nxt == 0) && !abort;
    e_deny  = (m_state == 0) && (ab == 2'b10) && full;
    e_fault = abort;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check_eq("state",     int'(state),     m_state);
    check_eq("gate_open", int'(gate_open), int'(m_state != 0));
    check_eq("car_in",    int'(car_in),    int'(e_in));
    check_eq("car_out",   int'(car_out),   int'(e_out));
    check_eq("deny",      int'(deny),      int'(e_deny));
    check_eq("fault",     int'(fault),     int'(e_fault));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_state"}, int'(state), 0);
    check_eq({tag, "_outs"}, int'({car_in, car_out, gate_open, deny, fault}), 0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare_all();
      if (car_in)  begin seen_in++;  last_in_cyc = cyc; $display("txn cycle %0d: car_in", cyc); end
      if (car_out) begin seen_out++; $display("txn cycle %0d: car_out", cyc); end
      if (fault)   begin seen_fault++; last_fault_cyc = cyc; $display("txn cycle %0d: fault", cyc); end
      if (deny && first_deny < 0) first_deny = cyc;
    end
  endtask

  task automatic seg(input bit a, input bit b, input bit f, input bit e, input int n);
    beam_a = a; beam_b = b; full = f; empty = e;
    run_cycles(n);
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check_zero("rst_hold");
    end
    reset = 1'b1;
  endtask

  function automatic int rnd_hold();
    if ($urandom_range(0, 9) == 0) return $urandom_range(60, 80);
    return $urandom_range(1, 25);
  endfunction

  function automatic bit rnd_q();
    return ($urandom_range(0, 3) == 0);
  endfunction

  int base_in, base_out, base_fault, c0, kind;

  initial begin
    build_table();
    model_reset();
    #2 reset = 1'b0;
    #1 check_zero("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // entry passage, one car_in six clocks after beam_b falls
    base_in = seen_in;
    seg(0, 0, 0, 0, 20); seg(1, 0, 0, 0, 20); seg(1, 1, 0, 0, 20); seg(0, 1, 0, 0, 20);
    c0 = cyc;
    seg(0, 0, 0, 0, 20);
    check_eq("entry_pulses", seen_in - base_in, 1);
    check_eq("entry_latency", last_in_cyc - c0, 6);

    // exit passage, then exit attempt with empty lot
    base_in = seen_in; base_out = seen_out;
    seg(0, 1, 0, 0, 20); seg(1, 1, 0, 0, 20); seg(1, 0, 0, 0, 20); seg(0, 0, 0, 0, 20);
    check_eq("exit_pulses", seen_out - base_out, 1);
    check_eq("exit_no_in", seen_in - base_in, 0);
    base_out = seen_out;
    seg(0, 1, 0, 1, 20);
    check_eq("empty_hold_state", int'(state), 0);
    seg(0, 0, 0, 1, 20);
    check_eq("empty_no_out", seen_out - base_out, 0);

    // full lot: deny after six clocks, clears on release
    first_deny = -1; c0 = cyc;
    seg(1, 0, 1, 0, 20);
    check_eq("deny_latency", first_deny - c0, 6);
    seg(0, 0, 1, 0, 20);
    check_eq("deny_clear", int'(deny), 0);

    // 3-clock glitch ignored, then a reversal out of IN_A
    base_in = seen_in;
    seg(1, 0, 0, 0, 3); seg(0, 0, 0, 0, 20);
    seg(1, 0, 0, 0, 20); seg(0, 0, 0, 0, 20);
    check_eq("reversal_no_pulse", seen_in - base_in, 0);

    // stalled passage: one fault, 6 + TMO clocks after beam_a rises
    base_fault = seen_fault; c0 = cyc;
    seg(1, 0, 0, 0, 90);
    check_eq("timeout_faults", seen_fault - base_fault, 1);
    check_eq("timeout_latency", last_fault_cyc - c0, 6 + TMO);
    seg(0, 0, 0, 0, 20);

    // reset mid-passage aborts silently
    base_in = seen_in;
    seg(1, 0, 0, 0, 20); seg(1, 1, 0, 0, 12);
    check_eq("pre_rst_state", int'(state), 2);
    pulse_reset(3);
    seg(1, 1, 0, 0, 15); seg(0, 1, 0, 0, 15); seg(0, 0, 0, 0, 20);
    check_eq("rst_no_pulse", seen_in - base_in, 0);

    // randomized traffic: scripted passages with random holds and lot flags, plus noise
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        seg(1, 0, rnd_q(), rnd_q(), rnd_hold()); seg(1, 1, rnd_q(), rnd_q(), rnd_hold());
        seg(0, 1, rnd_q(), rnd_q(), rnd_hold()); seg(0, 0, rnd_q(), rnd_q(), rnd_hold());
      end else if (kind < 8) begin
        seg(0, 1, rnd_q(), rnd_q(), rnd_hold()); seg(1, 1, rnd_q(), rnd_q(), rnd_hold());
        seg(1, 0, rnd_q(), rnd_q(), rnd_hold()); seg(0, 0, rnd_q(), rnd_q(), rnd_hold());
      end else begin
        repeat ($urandom_range(1, 3))
          seg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_q(), rnd_q(), rnd_hold());
      end
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
    end
    seg(0, 0, 0, 0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/garage_gate_ctrl.md
GARAGE_GATE_CTRL -- requirements
Module: garage_gate_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable clocks required before a beam change is accepted (range 1..255).
REQ-002 Parameter: TIMEOUT_CYCLES, 1000, clocks a passage may stall in one non-IDLE state before abort (range 2..65535).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 beam_a  input  1  raw outer light-beam sensor, 1 = blocked; asynchronous to clk.
REQ-006 beam_b  input  1  raw inner light-beam sensor, 1 = blocked; asynchronous to clk.
REQ-007 full  input  1  occupancy counter at maximum (50); synchronous to clk.
REQ-008 empty  input  1  occupancy counter at 0; synchronous to clk.
REQ-009 car_in  output  1  one-cycle pulse, one completed entry; drives the occupancy counter increment.
REQ-010 car_out  output  1  one-cycle pulse, one completed exit; drives the occupancy counter decrement.
REQ-011 gate_open  output  1  barrier open; high in every non-IDLE state.
REQ-012 deny  output  1  level; high while in IDLE with debounced {a,b}=10 and full=1.
REQ-013 fault  output  1  one-cycle pulse on passage timeout.
REQ-014 state  output  3  current FSM state encoding, for debug.

Function
REQ-015 Each beam SHALL pass through a 2-flop synchronizer, then a debouncer; debounced value flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clocks; the debounce counter clears on any agreement.
REQ-016 Latency raw beam edge -> debounced change SHALL be 2 + DEBOUNCE_CYCLES clocks; glitches shorter than DEBOUNCE_CYCLES clocks SHALL be ignored.
REQ-017 States and encoding: IDLE=0, IN_A=1, IN_AB=2, IN_B=3, OUT_B=4, OUT_BA=5, OUT_A=6; 7 unused and SHALL return to IDLE.
REQ-018 Transitions below use debounced {a,b}; any pair not listed holds the current state.
REQ-019 IDLE: 10 and full=0 -> IN_A; 10 and full=1 -> hold, deny=1; 01 and empty=0 -> OUT_B; 01 and empty=1 -> hold, no output; 11 -> hold.
REQ-020 IN_A: 11 -> IN_AB; 00 -> IDLE, no pulse (car backed out).
REQ-021 IN_AB: 01 -> IN_B; 10 -> IN_A.
REQ-022 IN_B: 00 -> IDLE with car_in=1 for exactly that one cycle; 11 -> IN_AB.
REQ-023 OUT_B: 11 -> OUT_BA; 00 -> IDLE, no pulse.
REQ-024 OUT_BA: 10 -> OUT_A; 01 -> OUT_B.
REQ-025 OUT_A: 00 -> IDLE with car_out=1 for exactly that one cycle; 11 -> OUT_BA.
REQ-026 car_in and car_out SHALL be registered, never high in the same cycle, at most one pulse per completed passage.
REQ-027 A timeout counter SHALL clear on every state change and while in IDLE; at TIMEOUT_CYCLES consecutive clocks in one non-IDLE state -> IDLE, fault=1 for one cycle, no car_in/car_out.
REQ-028 full/empty SHALL be sampled only on leaving IDLE; a change of full/empty mid-passage SHALL NOT abort the passage.
REQ-029 gate_open, deny, state SHALL be registered outputs.

Reset
REQ-030 On reset=0, asynchronously: state=IDLE, car_in=0, car_out=0, gate_open=0, deny=0, fault=0, synchronizers, debounced beams, debounce and timeout counters = 0.
REQ-031 Reset asserted mid-passage SHALL abort it with no pulse; after release the FSM SHALL start from IDLE with the current beams re-debounced from 0.

Verification
REQ-032 DEBOUNCE_CYCLES=4: beams 00->10->11->01->00, each held 20 clocks, full=0 -> exactly one car_in pulse, 6 clocks after the final beam_b fall; gate_open high for the whole passage.
REQ-033 Beams 00->01->11->10->00, empty=0 -> exactly one car_out pulse, no car_in; with empty=1 -> state stays 0, no pulse.
REQ-034 full=1, beam_a=1 held 20 clocks -> deny=1 from clock 6, gate_open=0, state=0; beam_a released -> deny=0.
REQ-035 3-clock pulse on beam_a with DEBOUNCE_CYCLES=4 -> no state change; 10->00 reversal from IN_A -> IDLE, no pulse.
REQ-036 TIMEOUT_CYCLES=64: beams 10 held indefinitely -> state 1 for 64 clocks, then state 0 with fault pulse of 1 cycle; reset=0 during IN_AB -> all outputs 0 immediately, no car_in.
